// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order front end: the dispatch
// FIFO entry layout, common opcodes, machine sizes and the write-back snoop
// helper used when DISPATCH_FWD_EN is defined.
package ooo_pkg;

  localparam int NUM_ROB           = 64;
  localparam int NUM_PHYSICAL_REGS = 64;
  localparam int PHYS_TAG_W        = $clog2(NUM_PHYSICAL_REGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [PHYS_TAG_W-1:0] dest;
    logic [PHYS_TAG_W-1:0] rs1;
    logic [PHYS_TAG_W-1:0] rs2;
    logic [31:0]           rs1_val;
    logic [31:0]           rs2_val;
    logic [6:0]            opcode;
    logic [31:0]           imm;
  } dispatch_entry_t;

  // Replaces stale operand values with a broadcast result. Tag 0 is the
  // hard-wired zero register and must never pick up a broadcast.
  function automatic dispatch_entry_t snoop_entry(
    input dispatch_entry_t       e,
    input logic                  wbValid,
    input logic [PHYS_TAG_W-1:0] wbTag,
    input logic [31:0]           wbData
  );
    dispatch_entry_t r;
    r = e;
    if (wbValid && (wbTag != '0)) begin
      if (e.rs1 == wbTag) r.rs1_val = wbData;
      if (e.rs2 == wbTag) r.rs2_val = wbData;
    end
    return r;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// In-order DEPTH-entry buffer between rename and issue-queue write.
// Push, pop, flush and occupancy count; with DISPATCH_FWD_EN defined every
// buffered entry (and the entry being written) snoops the write-back bus.
module dispatch_fifo
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  dispatch_entry_t       push_data_i,
  input  logic                  pop_i,
`ifdef DISPATCH_FWD_EN
  input  logic                  snoop_valid_i,
  input  logic [PHYS_TAG_W-1:0] snoop_tag_i,
  input  logic [31:0]           snoop_data_i,
`endif
  output dispatch_entry_t       head_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  dispatch_entry_t  mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  dispatch_entry_t  writeEntry;

  // Incoming entry, updated by a same-cycle broadcast when forwarding is built
  always_comb begin
`ifdef DISPATCH_FWD_EN
    writeEntry = snoop_entry(push_data_i, snoop_valid_i, snoop_tag_i, snoop_data_i);
`else
    writeEntry = push_data_i;
`endif
  end

  // Storage, pointers and occupancy; storage is cleared on reset so the head reads 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
`ifdef DISPATCH_FWD_EN
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= snoop_entry(mem_q[i], snoop_valid_i, snoop_tag_i, snoop_data_i);
`endif
      if (flush_i) begin
        rdPtr_q <= '0;
        wrPtr_q <= '0;
        count_q <= '0;
      end else begin
        if (push_i) begin
          mem_q[wrPtr_q] <= writeEntry;
          wrPtr_q        <= wrPtr_q + 1'b1;
        end
        if (pop_i) rdPtr_q <= rdPtr_q + 1'b1;
        if (push_i && !pop_i)      count_q <= count_q + 1'b1;
        else if (!push_i && pop_i) count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: buffers renamed instructions, allocates ROB slots against
// a credit counter and writes the head entry into the issue queue.
// DISPATCH_FWD_EN adds write-back snooping and same-cycle operand bypass;
// without it fwd_rs1/fwd_rs2 are tied to 0 and the wb_* inputs are unused.
module dispatch_unit #(
  parameter int DEPTH   = 4,
  parameter int NUM_ROB = ooo_pkg::NUM_ROB,
  parameter int PREG_W  = ooo_pkg::PHYS_TAG_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PREG_W-1:0]          in_phys_dest,
  input  logic [PREG_W-1:0]          in_phys_rs1,
  input  logic [PREG_W-1:0]          in_phys_rs2,
  input  logic [31:0]                in_rs1_val,
  input  logic [31:0]                in_rs2_val,
  input  logic [6:0]                 in_opcode,
  input  logic [31:0]                in_immediate,
  input  logic                       rob_commit,
  input  logic                       wb_valid,
  input  logic [PREG_W-1:0]          wb_tag,
  input  logic [31:0]                wb_data,
  input  logic                       issue_queue_full,
  output logic                       write_enable,
  output logic [PREG_W-1:0]          phys_dest,
  output logic [PREG_W-1:0]          phys_rs1,
  output logic [PREG_W-1:0]          phys_rs2,
  output logic [31:0]                phys_rs1_val,
  output logic [31:0]                phys_rs2_val,
  output logic [6:0]                 opcode,
  output logic [31:0]                immediate,
  output logic [$clog2(NUM_ROB)-1:0] ROB_entry_index,
  output logic [31:0]                fwd_rs1,
  output logic [31:0]                fwd_rs2
);

  import ooo_pkg::*;

  localparam int ROB_W  = $clog2(NUM_ROB);
  localparam int CRED_W = $clog2(NUM_ROB + 1);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  dispatch_entry_t   pushEntry;
  dispatch_entry_t   headEntry;
  logic [CNT_W-1:0]  fifoCount;
  logic              headValid;
  logic              doPush;
  logic              doDispatch;
  logic [ROB_W-1:0]  robTail_q, robTail_d;
  logic [CRED_W-1:0] credits_q, credits_d;

  // Capture every rename field into one FIFO entry
  always_comb begin
    pushEntry         = '0;
    pushEntry.dest    = in_phys_dest;
    pushEntry.rs1     = in_phys_rs1;
    pushEntry.rs2     = in_phys_rs2;
    pushEntry.rs1_val = in_rs1_val;
    pushEntry.rs2_val = in_rs2_val;
    pushEntry.opcode  = in_opcode;
    pushEntry.imm     = in_immediate;
  end

  // in_ready only looks at registered occupancy, so issue_queue_full never reaches it
  assign in_ready   = (fifoCount < CNT_W'(DEPTH));
  assign headValid  = (fifoCount != '0);
  assign doPush     = in_valid && in_ready && !flush;
  assign doDispatch = headValid && !issue_queue_full && (credits_q != '0) && !flush;

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush),
    .push_i        (doPush),
    .push_data_i   (pushEntry),
    .pop_i         (doDispatch),
`ifdef DISPATCH_FWD_EN
    .snoop_valid_i (wb_valid),
    .snoop_tag_i   (wb_tag),
    .snoop_data_i  (wb_data),
`endif
    .head_o        (headEntry),
    .count_o       (fifoCount)
  );

  // Next ROB tail and credit count; a commit at full credit has nowhere to go
  always_comb begin
    robTail_d = robTail_q;
    credits_d = credits_q;
    if (flush) begin
      robTail_d = '0;
      credits_d = CRED_W'(NUM_ROB);
    end else begin
      if (doDispatch)
        robTail_d = (robTail_q == ROB_W'(NUM_ROB - 1)) ? '0 : robTail_q + 1'b1;
      if (doDispatch && !rob_commit)
        credits_d = credits_q - 1'b1;
      else if (!doDispatch && rob_commit && (credits_q != CRED_W'(NUM_ROB)))
        credits_d = credits_q + 1'b1;
    end
  end

  // ROB allocation state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      robTail_q <= '0;
      credits_q <= CRED_W'(NUM_ROB);
    end else begin
      robTail_q <= robTail_d;
      credits_q <= credits_d;
    end
  end

  assign write_enable    = doDispatch;
  assign phys_dest       = headEntry.dest;
  assign phys_rs1        = headEntry.rs1;
  assign phys_rs2        = headEntry.rs2;
  assign phys_rs1_val    = headEntry.rs1_val;
  assign phys_rs2_val    = headEntry.rs2_val;
  assign opcode          = headEntry.opcode;
  assign immediate       = headEntry.imm;
  assign ROB_entry_index = robTail_q;

`ifdef DISPATCH_FWD_EN
  assign fwd_rs1 = (wb_valid && (wb_tag != '0) && (wb_tag == headEntry.rs1)) ? wb_data : headEntry.rs1_val;
  assign fwd_rs2 = (wb_valid && (wb_tag != '0) && (wb_tag == headEntry.rs2)) ? wb_data : headEntry.rs2_val;
`else
  logic unusedWb;
  assign unusedWb = ^{wb_valid, wb_tag, wb_data};
  assign fwd_rs1  = '0;
  assign fwd_rs2  = '0;
`endif

endmodule
